// File: rtl/vga_timing_pkg.sv
// Shared raster timing for the display path: default 640x480@60 constants
// and helpers that derive line/frame totals and sync window bounds.
package vga_timing_pkg;

  localparam int unsigned DEF_CLK_DIV  = 4;
  localparam int unsigned DEF_CNT_W    = 10;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;

  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  function automatic int unsigned span_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int unsigned sync_first(input int unsigned active,
                                             input int unsigned fp);
    return active + fp;
  endfunction

  function automatic int unsigned sync_last(input int unsigned active,
                                            input int unsigned fp,
                                            input int unsigned sync);
    return active + fp + sync - 1;
  endfunction

  localparam int unsigned DEF_H_TOTAL  = span_total(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP);
  localparam int unsigned DEF_V_TOTAL  = span_total(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP);
  localparam int unsigned DEF_HS_START = sync_first(DEF_H_ACTIVE, DEF_H_FP);
  localparam int unsigned DEF_HS_END   = sync_last(DEF_H_ACTIVE, DEF_H_FP, DEF_H_SYNC);
  localparam int unsigned DEF_VS_START = sync_first(DEF_V_ACTIVE, DEF_V_FP);
  localparam int unsigned DEF_VS_END   = sync_last(DEF_V_ACTIVE, DEF_V_FP, DEF_V_SYNC);

endpackage

// File: rtl/pixel_clk_div.sv
// Pixel-rate enable generator: tick_o pulses once every CLK_DIV enabled clocks.
// The count freezes while en_i is low so a paused raster resumes mid-pixel.
module pixel_clk_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  assign tick_o = en_i && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en_i) div_d = tick_o ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= '0;
    else        div_q <= div_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel divider, h/v counters, sync, active-video and
// line/frame strobes. Every output is registered from the next counter values.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
  parameter int unsigned H_FP      = DEF_H_FP,
  parameter int unsigned H_SYNC    = DEF_H_SYNC,
  parameter int unsigned H_BP      = DEF_H_BP,
  parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
  parameter int unsigned V_FP      = DEF_V_FP,
  parameter int unsigned V_SYNC    = DEF_V_SYNC,
  parameter int unsigned V_BP      = DEF_V_BP,
  parameter bit          HSYNC_POL = 1'b0,
  parameter bit          VSYNC_POL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             pixel_stb,
  output logic             line_start,
  output logic             frame_start
);

  localparam int unsigned H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(sync_first(H_ACTIVE, H_FP));
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(sync_last(H_ACTIVE, H_FP, H_SYNC));
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(sync_first(V_ACTIVE, V_FP));
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(sync_last(V_ACTIVE, V_FP, V_SYNC));

  logic             tick;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             hsync_q, vsync_q, video_on_q;
  logic             pixel_stb_q, line_start_q, frame_start_q;

  pixel_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .tick_o (tick)
  );

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (tick) begin
      if (h_q < H_LAST) begin
        h_d = h_q + 1'b1;
      end else begin
        h_d = '0;
        v_d = (v_q < V_LAST) ? v_q + 1'b1 : '0;
      end
    end
  end

  // Levels decode from the next position so they land on the same edge as the counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b1;
      pixel_stb_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      hsync_q       <= (h_d >= HS_START && h_d <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_q       <= (v_d >= VS_START && v_d <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
      video_on_q    <= (h_d < H_ACT_C) && (v_d < V_ACT_C);
      pixel_stb_q   <= tick;
      line_start_q  <= tick && (h_d == '0);
      frame_start_q <= tick && (h_d == '0) && (v_d == '0);
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pixel_stb   = pixel_stb_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line/freeze/reset behaviour and
// a tiny-timing CLK_DIV=1 instance for whole-frame behaviour.
module tb_vga_timing_gen;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst0_n, en0, rst1_n, en1;
  logic [W-1:0] h0, v0, h1, v1;
  logic         hs0, vs0, vo0, ps0, ls0, fs0;
  logic         hs1, vs1, vo1, ps1, ls1, fs1;

  vga_timing_gen dut0 (
    .clk(clk), .rst_n(rst0_n), .en(en0),
    .h_count(h0), .v_count(v0), .hsync(hs0), .vsync(vs0), .video_on(vo0),
    .pixel_stb(ps0), .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .CNT_W(W), .HSYNC_POL(1'b1), .VSYNC_POL(1'b0),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut1 (
    .clk(clk), .rst_n(rst1_n), .en(en1),
    .h_count(h1), .v_count(v1), .hsync(hs1), .vsync(vs1), .video_on(vo1),
    .pixel_stb(ps1), .line_start(ls1), .frame_start(fs1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // dut0 line statistics
  int hs_low_px, hs_first, hs_last, vo_low_px, px_cnt, first_ls, ls_h, ls_v, h_before, ls_no_stb;
  // dut1 frame statistics
  int hs1_hi, hs1_first, vs1_lo, vo1_hi, ls1_cnt, fs1_cnt, ps1_cnt, fs1_cyc, v1_before, h1_before;
  int stb_frz, h_chg, found, cyc;

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0; en0 = 1'b1; en1 = 1'b1;
    hs_low_px = 0; hs_first = -1; hs_last = -1; vo_low_px = 0; px_cnt = 0;
    first_ls = 0; ls_h = -1; ls_v = -1; h_before = -1; ls_no_stb = 0;
    hs1_hi = 0; hs1_first = -1; vs1_lo = 0; vo1_hi = 0; ls1_cnt = 0; fs1_cnt = 0;
    ps1_cnt = 0; fs1_cyc = 0; v1_before = -1; h1_before = -1;

    step(3);
    check("rst_h",        int'(h0), 0);
    check("rst_v",        int'(v0), 0);
    check("rst_video_on", int'(vo0), 1);
    check("rst_hsync",    int'(hs0), 1);
    check("rst_vsync",    int'(vs0), 1);
    check("rst_strobes",  int'({ps0, ls0, fs0}), 0);
    check("rst1_hsync",   int'(hs1), 0);
    check("rst1_vsync",   int'(vs1), 1);

    rst0_n = 1'b1; rst1_n = 1'b1;
    for (int c = 1; c <= 3200; c++) begin
      step(1);
      if (c == 3) check("stb_not_yet", int'(ps0), 0);
      if (c == 4) begin
        check("first_stb",   int'(ps0), 1);
        check("first_stb_h", int'(h0), 1);
      end
      if (ps0) px_cnt++;
      if (ps0 && !hs0) begin
        hs_low_px++;
        if (hs_first < 0) hs_first = int'(h0);
        hs_last = int'(h0);
      end
      if (ps0 && !vo0) vo_low_px++;
      if (ls0 && !ps0) ls_no_stb++;
      if (ls0 && first_ls == 0) begin
        first_ls = c; ls_h = int'(h0); ls_v = int'(v0);
      end else if (ps0 && first_ls == 0) begin
        h_before = int'(h0);
      end
      if (c <= 98) begin
        if (ps1) ps1_cnt++;
        if (hs1) begin
          hs1_hi++;
          if (hs1_first < 0) hs1_first = int'(h1);
        end
        if (!vs1) vs1_lo++;
        if (vo1) vo1_hi++;
        if (ls1) ls1_cnt++;
        if (fs1) begin
          fs1_cnt++;
          if (fs1_cyc == 0) fs1_cyc = c;
        end else begin
          v1_before = int'(v1); h1_before = int'(h1);
        end
      end
    end
    check("line_clks",        first_ls, 3200);
    check("line_wrap_h",      ls_h, 0);
    check("line_wrap_v",      ls_v, 1);
    check("line_h_before",    h_before, 799);
    check("line_pixels",      px_cnt, 800);
    check("hsync_low_px",     hs_low_px, 96);
    check("hsync_first",      hs_first, 656);
    check("hsync_last",       hs_last, 751);
    check("video_off_px",     vo_low_px, 160);
    check("ls_without_stb",   ls_no_stb, 0);

    check("f1_stb_cnt",       ps1_cnt, 98);
    check("f1_hsync_hi",      hs1_hi, 14);
    check("f1_hsync_first_h", hs1_first, 10);
    check("f1_vsync_lo",      vs1_lo, 14);
    check("f1_video_on",      vo1_hi, 32);
    check("f1_line_starts",   ls1_cnt, 7);
    check("f1_frame_starts",  fs1_cnt, 1);
    check("f1_frame_clks",    fs1_cyc, 98);
    check("f1_v_before_wrap", v1_before, 6);
    check("f1_h_before_wrap", h1_before, 13);

    // freeze dut0 two clocks after the h=100 strobe
    found = 0;
    for (int c = 0; c < 1000 && found == 0; c++) begin
      step(1);
      if (ps0 && h0 == 10'd100) found = 1;
    end
    check("wait_h100", found, 1);
    step(2);
    en0 = 1'b0;
    stb_frz = 0; h_chg = 0;
    for (int c = 0; c < 7; c++) begin
      step(1);
      if (ps0 || ls0 || fs0) stb_frz++;
      if (h0 != 10'd100) h_chg++;
    end
    check("freeze_strobes", stb_frz, 0);
    check("freeze_h_moves", h_chg, 0);
    en0 = 1'b1;
    step(1);
    check("resume1_h",   int'(h0), 100);
    check("resume1_stb", int'(ps0), 0);
    step(1);
    check("resume2_h",   int'(h0), 101);
    check("resume2_stb", int'(ps0), 1);

    // async reset of dut0 in the middle of its hsync pulse
    found = 0;
    for (int c = 0; c < 4000 && found == 0; c++) begin
      step(1);
      if (ps0 && h0 == 10'd700) found = 1;
    end
    check("wait_h700", found, 1);
    #3;
    rst0_n = 1'b0;
    #1;
    check("arst_h",       int'(h0), 0);
    check("arst_v",       int'(v0), 0);
    check("arst_hsync",   int'(hs0), 1);
    check("arst_vid",     int'(vo0), 1);
    check("arst_strobes", int'({ps0, ls0, fs0}), 0);
    step(1);
    rst0_n = 1'b1;

    // async reset of dut1 at (11,5): hsync/vsync asserted, video off
    found = 0;
    for (int c = 0; c < 200 && found == 0; c++) begin
      step(1);
      if (h1 == 10'd11 && v1 == 10'd5) found = 1;
    end
    check("wait_h11_v5", found, 1);
    check("pre_arst1_hsync", int'(hs1), 1);
    check("pre_arst1_vsync", int'(vs1), 0);
    #2;
    rst1_n = 1'b0;
    #1;
    check("arst1_pos",   int'({h1, v1}), 0);
    check("arst1_hsync", int'(hs1), 0);
    check("arst1_vsync", int'(vs1), 1);
    check("arst1_vid",   int'(vo1), 1);
    step(2);
    rst1_n = 1'b1;
    cyc = 0;
    found = 0;
    for (int c = 1; c <= 200 && found == 0; c++) begin
      step(1);
      if (fs1) begin
        found = 1;
        cyc = c;
      end
    end
    check("arst1_next_frame", cyc, 98);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
